// File: rtl/alu_flag_sequencer.sv
// alu_flag_sequencer
// Multi-cycle controller for the shared ALU and flag unit. It runs one decoded
// instruction at a time:
//   IDLE -> EXEC -> (EVAL if conditional) -> DONE -> IDLE
// The decoder gets a start/busy/done handshake. The ALU and flag unit are
// driven only from fields captured on start.
module alu_flag_sequencer #(
    parameter int         WIDTH      = 16,
    parameter logic [2:0] ALUOP_IDLE = 3'b000,
    parameter int         CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       req_aluop,
    input  logic             req_setflags,
    input  logic             req_cond,
    input  logic [3:0]       req_op,
    input  logic [2:0]       req_cc,
    input  logic [WIDTH-1:0] ALUO,
    input  logic             Perform,
    output logic [2:0]       ALUOp,
    output logic             FU,
    output logic [3:0]       Op,
    output logic [2:0]       CC,
    output logic             busy,
    output logic             done,
    output logic             result_we,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] skip_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_EVAL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       aluop_q;
    logic             setflags_q;
    logic             cond_q;
    logic [3:0]       op_q;
    logic [2:0]       cc_q;
    logic [WIDTH-1:0] result_q;
    logic             perform_q;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic             skipped;

    // A conditional op that evaluated false is counted as skipped in DONE.
    assign skipped = (state_q == ST_DONE) && cond_q && !perform_q;

    // Next-state selection. Start is only honoured in IDLE; a start seen
    // while busy is dropped without being queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_EXEC;
            ST_EXEC: state_d = cond_q ? ST_EVAL : ST_DONE;
            ST_EVAL: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The skipped-op counter saturates at all-ones instead of wrapping.
    always_comb begin
        skip_d = skip_q;
        if (skipped && (skip_q != {CNT_W{1'b1}})) begin
            skip_d = skip_q + 1'b1;
        end
    end

    // State, the request latch, the result capture and the perform capture.
    // Reset takes priority over a start in the same cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            aluop_q    <= ALUOP_IDLE;
            setflags_q <= 1'b0;
            cond_q     <= 1'b0;
            op_q       <= '0;
            cc_q       <= '0;
            result_q   <= '0;
            perform_q  <= 1'b0;
            skip_q     <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            if ((state_q == ST_IDLE) && start) begin
                aluop_q    <= req_aluop;
                setflags_q <= req_setflags;
                cond_q     <= req_cond;
                op_q       <= req_op;
                cc_q       <= req_cc;
            end
            // ALUO is only meaningful during EXEC, and Perform only during EVAL.
            if (state_q == ST_EXEC) begin
                result_q <= ALUO;
            end
            if (state_q == ST_EVAL) begin
                perform_q <= Perform;
            end
        end
    end

    // Datapath controls and handshake, decoded from the state and the latched
    // request. Outside EXEC the ALU op is idle and flags are never updated.
    always_comb begin
        ALUOp     = ALUOP_IDLE;
        FU        = 1'b0;
        Op        = '0;
        CC        = '0;
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;
        result_we = 1'b0;
        case (state_q)
            ST_EXEC: begin
                ALUOp = aluop_q;
                FU    = setflags_q;
            end
            ST_EVAL: begin
                Op = op_q;
                CC = cc_q;
            end
            ST_DONE: begin
                done      = 1'b1;
                result_we = cond_q ? perform_q : 1'b1;
            end
            default: ;
        endcase
    end

    assign result     = result_q;
    assign skip_count = skip_q;

endmodule

// File: doc/alu_flag_sequencer.md
Name: alu_flag_sequencer

Overview:
Multi-cycle controller that sequences the shared 16-bit ALU and flag unit for one decoded instruction at a time.
- Drives ALUOp/FU in an execute cycle, then optionally Op/CC in a condition-evaluate cycle, and samples Perform.
- Captures the ALU result and issues a single-cycle completion with a write-enable qualified by the condition.
- Sits between the instruction decoder and the ALU/flag datapath; the decoder sees a start/busy/done handshake.

Parameters:
WIDTH, 16, datapath width of the ALU operands and result
ALUOP_IDLE, 3'b000, ALUOp value driven while not in EXEC
CNT_W, 8, width of the saturating skipped-operation counter

Ports:
CLK  input  1  system clock; all state changes on rising edge
Reset  input  1  synchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
req_aluop  input  3  ALU operation for this instruction
req_setflags  input  1  1 = flag unit updates during EXEC
req_cond  input  1  1 = instruction is conditional (EVAL cycle inserted)
req_op  input  4  condition Op field for the flag unit
req_cc  input  3  condition code field for the flag unit
ALUO  input  WIDTH  ALU result from datapath
Perform  input  1  condition result from flag unit
ALUOp  output  3  ALU operation select
FU  output  1  flag-update enable
Op  output  4  condition Op to flag unit
CC  output  3  condition code to flag unit
busy  output  1  high in EXEC, EVAL and DONE
done  output  1  one-cycle completion pulse
result_we  output  1  valid with done; 1 = write result back
result  output  WIDTH  registered ALU result
skip_count  output  CNT_W  saturating count of conditional ops with Perform=0

Behaviour:
- Reset values: state=IDLE; ALUOp=ALUOP_IDLE; FU=0; Op=0; CC=0; busy=0; done=0; result_we=0; result=0; skip_count=0.
- Request latch: on start in IDLE, the req_* fields are registered. Outputs are then driven from the registered fields, never from the live inputs.
- IDLE: outputs at their idle values.
  - start=1 -> EXEC next cycle.
  - start=0 -> stay in IDLE.
- EXEC (1 cycle):
  - ALUOp=latched aluop; FU=latched setflags; Op/CC=0.
  - At the end of the cycle, result <= ALUO. Flags latch in the datapath on the same edge.
  - Next state: EVAL if req_cond=1, else DONE.
- EVAL (1 cycle):
  - ALUOp=ALUOP_IDLE; FU=0 (flags must not change); Op/CC=latched values.
  - At the end of the cycle, the registered perform bit <= Perform.
  - Next state: DONE.
- DONE (1 cycle):
  - done=1; result_we = (req_cond ? perform_reg : 1); ALUOp idle, FU=0, Op/CC=0.
  - If req_cond=1 and perform_reg=0, skip_count increments, saturating at all-ones.
  - Next state: IDLE.
- Latency from the start cycle to the done cycle: 2 cycles for unconditional ops, 3 cycles for conditional ops. The next start is accepted the cycle after done.
- start while busy=1 (including DONE) is ignored; no queueing.
- result holds its value until the next EXEC; result_we and done are 0 outside DONE.
- Reset asserted in any state: return to IDLE next edge, all outputs to reset values, no done pulse, skip_count cleared.
- Simultaneous Reset and start: Reset wins; the request is dropped.
- Perform and ALUO are ignored outside EVAL and EXEC respectively.

Test Plan:
1. Unconditional op: req_aluop=010, req_setflags=0, req_cond=0, bench ALUO=16'h0007 during EXEC.
   -> ALUOp=010 for exactly 1 cycle; done 2 cycles after start; result=16'h0007; result_we=1; FU never high.
2. Conditional taken: req_aluop=010, req_setflags=1, req_op=4'b0100, req_cc=3'b111, ALUO=16'h0007, Perform=1 in EVAL.
   -> FU=1 only in EXEC; Op=0100/CC=111 only in EVAL; done at +3; result_we=1; result=16'h0007; skip_count=0.
3. Conditional not taken: req_aluop=000, req_op=4'b0000, req_cc=3'b010, ALUO=16'h0002, Perform=0.
   -> done at +3; result_we=0; result=16'h0002; skip_count=1.
4. Busy rejection: second start with req_aluop=011 asserted in EXEC and DONE of a running op.
   -> ignored; ALUOp never shows 011; exactly one done pulse; a start one cycle after done is accepted.
5. Reset mid-op: Reset high during EVAL of a conditional op.
   -> next cycle state=IDLE, busy=0, done never pulses, all outputs at reset values, skip_count=0.
6. Saturation: 2^CNT_W+2 not-taken conditional ops back to back.
   -> skip_count stops at 8'hFF and holds.
